vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
//
// A clock divider produces a one-clk pixel strobe (pix_en) every CLK_DIV system
// clocks. On each strobe the column counter advances; the line counter advances
// when the column wraps. Sync and blanking flags are derived from the next-state
// counter values and registered on the same edge as the counters, so all outputs
// change together with zero skew.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   hCount     out  [9:0] current pixel column (registered)
//   vCount     out  [9:0] current line (registered)
//   hSync      out  active-low horizontal sync (registered)
//   vSync      out  active-low vertical sync (registered)
//   bright     out  high inside the visible window (registered)
//   pix_en     out  one-clk pulse on the clk whose edge advances the counters
//   frame_tick out  only with VGA_FRAME_TICK_EN defined: one-clk pulse after the
//                   edge that wraps both counters to 0 (registered)
//
// Optional feature macro: VGA_FRAME_TICK_EN
module vga_timing_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 783,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 514
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_en
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_S  = 10'(H_ACT_START);
    localparam logic [9:0] H_ACT_E  = 10'(H_ACT_END);
    localparam logic [9:0] V_ACT_S  = 10'(V_ACT_START);
    localparam logic [9:0] V_ACT_E  = 10'(V_ACT_END);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_bright;

    logic       w_pix_en;
    logic       w_line_end;
    logic       w_frame_end;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;

    always_comb begin
        w_pix_en    = (r_div == DIV_LAST);
        w_line_end  = w_pix_en && (r_hcount == H_LAST);
        w_frame_end = w_line_end && (r_vcount == V_LAST);

        w_h_next = r_hcount;
        if (w_pix_en) begin
            w_h_next = (r_hcount == H_LAST) ? 10'd0 : r_hcount + 10'd1;
        end

        w_v_next = r_vcount;
        if (w_line_end) begin
            w_v_next = (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_hcount <= 10'd0;
            r_vcount <= 10'd0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_bright <= 1'b0;
        end else begin
            r_div    <= w_pix_en ? '0 : r_div + 1'b1;
            r_hcount <= w_h_next;
            r_vcount <= w_v_next;
            // Flags use next-state counters so they land on the same edge.
            r_hsync  <= (w_h_next >= H_SYNC_C);
            r_vsync  <= (w_v_next >= V_SYNC_C);
            r_bright <= (w_h_next >= H_ACT_S) && (w_h_next <= H_ACT_E) &&
                        (w_v_next >= V_ACT_S) && (w_v_next <= V_ACT_E);
        end
    end

    assign hCount = r_hcount;
    assign vCount = r_vcount;
    assign hSync  = r_hsync;
    assign vSync  = r_vsync;
    assign bright = r_bright;
    // Decoded from the divider register; zero throughout reset since div is 0.
    assign pix_en = w_pix_en;

`ifdef VGA_FRAME_TICK_EN
    logic r_frame_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
        end
    end

    assign frame_tick = r_frame_tick;
`else
    logic w_unused_frame_end;
    assign w_unused_frame_end = w_frame_end;
`endif

endmodule
